// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (IF) and load/store (D) requesters.
// Optional IF starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  if (DATA_W % 8 != 0 || MAX_D_STREAK < 1 ||
      MAX_D_STREAK > 15) begin : g_bad_param
    $error("mem_port_arbiter: illegal parameter");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_IF,
    S_REQ_D,
    S_WAIT_IF,
    S_WAIT_D
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_if_win;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] r_streak;

  // Counts D grants taken while a fetch was left waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_streak <= '0;
    end else if (if_gnt) begin
      r_streak <= '0;
    end else if (r_state == S_IDLE && !if_req) begin
      r_streak <= '0;
    end else if (d_gnt && if_req && r_streak != 4'hF) begin
      r_streak <= r_streak + 4'd1;
    end
  end

  assign w_if_win = if_req &&
    (!d_req || r_streak == 4'(MAX_D_STREAK));
`else
  assign w_if_win = if_req && !d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_gnt     = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_if_win) begin
          w_next = S_REQ_IF;
        end else if (d_req) begin
          w_next = S_REQ_D;
        end
      end
      S_REQ_IF: begin
        // A withdrawn request falls back to IDLE without a grant.
        if (if_req) begin
          mem_req  = 1'b1;
          mem_be   = '1;
          mem_addr = if_addr;
          if_gnt   = mem_gnt;
          if (mem_gnt) begin
            w_next = S_WAIT_IF;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_REQ_D: begin
        if (d_req) begin
          mem_req   = 1'b1;
          mem_we    = d_we;
          mem_be    = d_be;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
          d_gnt     = mem_gnt;
          if (mem_gnt) begin
            w_next = S_WAIT_D;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WAIT_IF: begin
        if (mem_rvalid) begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
          w_next    = S_IDLE;
        end
      end
      S_WAIT_D: begin
        if (mem_rvalid) begin
          d_rvalid = 1'b1;
          d_rdata  = mem_rdata;
          w_next   = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Inputs change 1ns after posedge; outputs checked 1ns later.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_be       (d_be),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [1:0] grants [10];
  int         n_g;

  initial begin
    rst = 1'b0;
    if_req = 0; if_addr = 0;
    d_req = 0; d_we = 0; d_be = 0;
    d_addr = 0; d_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

    // reset state
    tick();
    settle();
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    tick();
    rst = 1'b1;

    // 1: fetch only
    tick();
    if_req = 1; if_addr = 32'h100;
    settle();
    chk("t1_idle_mem_req", mem_req, 0);
    tick();
    mem_gnt = 1;
    settle();
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_we", mem_we, 0);
    chk("t1_mem_be", mem_be, 4'hF);
    chk("t1_if_gnt", if_gnt, 1);
    chk("t1_d_gnt", d_gnt, 0);
    tick();
    if_req = 0; mem_gnt = 0;
    settle();
    chk("t1_wait_mem_req", mem_req, 0);
    chk("t1_wait_busy", busy, 1);
    chk("t1_wait_rdata", if_rdata, 0);
    tick();
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    settle();
    chk("t1_if_rvalid", if_rvalid, 1);
    chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("t1_d_rvalid", d_rvalid, 0);
    chk("t1_d_rdata", d_rdata, 0);
    tick();
    mem_rvalid = 0; mem_rdata = 0;
    settle();
    chk("t1_end_busy", busy, 0);

    // 2: simultaneous, D first then IF
    if_req = 1; if_addr = 32'h200;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h80;
    tick();
    mem_gnt = 1;
    settle();
    chk("t2_mem_addr_d", mem_addr, 32'h80);
    chk("t2_d_gnt", d_gnt, 1);
    chk("t2_if_gnt0", if_gnt, 0);
    tick();
    d_req = 0; mem_gnt = 0;
    tick();
    mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    settle();
    chk("t2_d_rvalid", d_rvalid, 1);
    chk("t2_d_rdata", d_rdata, 32'hCAFEF00D);
    chk("t2_if_rvalid0", if_rvalid, 0);
    tick();
    mem_rvalid = 0; mem_rdata = 0;
    settle();
    chk("t2_idle_busy", busy, 0);
    tick();
    mem_gnt = 1;
    settle();
    chk("t2_mem_addr_if", mem_addr, 32'h200);
    chk("t2_if_gnt", if_gnt, 1);
    chk("t2_d_gnt0", d_gnt, 0);
    tick();
    if_req = 0; mem_gnt = 0;
    tick();
    mem_rvalid = 1; mem_rdata = 32'h0BADF00D;
    settle();
    chk("t2_if_rvalid", if_rvalid, 1);
    chk("t2_if_rdata", if_rdata, 32'h0BADF00D);
    tick();
    mem_rvalid = 0; mem_rdata = 0;

    // 3: store with grant stall
    d_req = 1; d_we = 1; d_be = 4'h3;
    d_addr = 32'h40; d_wdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      chk("t3_mem_req", mem_req, 1);
      chk("t3_mem_addr", mem_addr, 32'h40);
      chk("t3_mem_wdata", mem_wdata, 32'h12345678);
      chk("t3_mem_we", mem_we, 1);
      chk("t3_mem_be", mem_be, 4'h3);
      chk("t3_d_gnt0", d_gnt, 0);
    end
    tick();
    mem_gnt = 1;
    settle();
    chk("t3_d_gnt", d_gnt, 1);
    tick();
    d_req = 0; d_we = 0; d_be = 0;
    d_addr = 0; d_wdata = 0; mem_gnt = 0;
    settle();
    chk("t3_wait_mem_req", mem_req, 0);
    chk("t3_wait_d_rvalid", d_rvalid, 0);
    tick();
    mem_rvalid = 1;
    settle();
    chk("t3_d_rvalid", d_rvalid, 1);
    tick();
    mem_rvalid = 0;
    settle();
    chk("t3_end_busy", busy, 0);

    // 4: reset while in WAIT_D
    d_req = 1; d_addr = 32'h44; d_be = 4'hF;
    tick();
    mem_gnt = 1;
    settle();
    chk("t4_d_gnt", d_gnt, 1);
    tick();
    d_req = 0; mem_gnt = 0;
    settle();
    chk("t4_wait_busy", busy, 1);
    rst = 0;
    settle();
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_mem_req", mem_req, 0);
    tick();
    rst = 1; mem_rvalid = 1; mem_rdata = 32'h55AA55AA;
    settle();
    chk("t4_late_d_rvalid", d_rvalid, 0);
    chk("t4_late_d_rdata", d_rdata, 0);
    chk("t4_late_busy", busy, 0);
    tick();
    mem_rvalid = 0; mem_rdata = 0;

    // 6: spurious response in IDLE
    mem_rvalid = 1; mem_rdata = 32'hFFFFFFFF;
    settle();
    chk("t6_if_rvalid", if_rvalid, 0);
    chk("t6_d_rvalid", d_rvalid, 0);
    chk("t6_if_rdata", if_rdata, 0);
    tick();
    settle();
    chk("t6_busy", busy, 0);
    mem_rvalid = 0; mem_rdata = 0;
    tick();

    // 5: both requesters held, memory always ready
    if_req = 1; if_addr = 32'h300;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h90;
    mem_gnt = 1; mem_rvalid = 1;
    n_g = 0;
    for (int c = 0; c < 40 && n_g < 10; c++) begin
      tick();
      settle();
      if (d_gnt || if_gnt) begin
        grants[n_g] = {if_gnt, d_gnt};
        n_g++;
      end
    end
    chk("t5_grant_count", n_g, 10);
    for (int k = 0; k < 10; k++) begin
`ifdef ARB_STARVE_GUARD_EN
      chk($sformatf("t5_grant%0d", k), grants[k],
          (k % 5 == 4) ? 2'b10 : 2'b01);
`else
      chk($sformatf("t5_grant%0d", k), grants[k], 2'b01);
`endif
    end
    if_req = 0; d_req = 0; mem_gnt = 0;
    tick();
    tick();
    mem_rvalid = 0;
    tick();
    settle();
    chk("t5_end_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
